// File: rtl/johnson_counter_param_if.sv
// Control and status bundle for johnson_counter_param.
//   slave  : counter side (takes iEnable/iDir/iLoad/iLoadData, drives oSalida/oPhase/oWrap/oIllegal)
//   master : controller side (opposite directions)
interface johnson_counter_param_if #(
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned PHW = $clog2(2 * WIDTH);

  logic             iEnable;
  logic             iDir;
  logic             iLoad;
  logic [WIDTH-1:0] iLoadData;
  logic [WIDTH-1:0] oSalida;
  logic [PHW-1:0]   oPhase;
  logic             oWrap;
  logic             oIllegal;

  modport slave (
    input  iEnable, iDir, iLoad, iLoadData,
    output oSalida, oPhase, oWrap, oIllegal
  );

  modport master (
    output iEnable, iDir, iLoad, iLoadData,
    input  oSalida, oPhase, oWrap, oIllegal
  );
endinterface

// File: rtl/johnson_counter_param.sv
// Parametrised Johnson (twisted-ring) counter with 2*WIDTH states.
// Features: enable, up/down direction, synchronous parallel load, step
// prescaler, phase decode, one-cycle wrap pulse and illegal-code flag.
// Optional macro JOHNSON_SELFCORRECT_EN: a step taken from an illegal code
// returns the ring to all-zeros instead of shifting.
// Ports:
//   iClk   - clock, rising edge
//   iReset - asynchronous, active-high reset
//   bus    - johnson_counter_param_if.slave (enable/dir/load in, state/phase/wrap/illegal out)
// oPhase and oIllegal are combinational decodes of the registered ring.
module johnson_counter_param #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 1
) (
  input  logic                    iClk,
  input  logic                    iReset,
  johnson_counter_param_if.slave  bus
);
  localparam int unsigned PHW  = $clog2(2 * WIDTH);
  localparam int unsigned PSW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned CW   = $clog2(WIDTH + 1);
  localparam int unsigned LAST = PRESCALE - 1;

  logic [WIDTH-1:0] q;
  logic [PSW-1:0]   presc;
  logic             wrap;

  logic [CW-1:0]    ones_c;
  logic [CW-1:0]    edges_c;
  logic             valid_c;
  logic [PHW-1:0]   phase_c;
  logic [WIDTH-1:0] shift_c;
  logic [WIDTH-1:0] next_c;
  logic             wrap_c;
  logic             due_c;

  // Code classification: a Johnson code has at most one adjacent-bit transition.
  // Among valid codes, MSB set (or all-zero) means 1^k 0^(W-k) -> phase k,
  // otherwise 0^(W-b) 1^b -> phase 2W-b.
  always_comb begin
    ones_c  = '0;
    edges_c = '0;
    for (int i = 0; i < WIDTH; i++) ones_c = ones_c + CW'(q[i]);
    for (int i = 0; i < WIDTH - 1; i++) edges_c = edges_c + CW'(q[i] ^ q[i+1]);
    valid_c = (edges_c <= CW'(1));
    phase_c = '0;
    if (valid_c) begin
      if (q[WIDTH-1] || (ones_c == '0)) phase_c = PHW'(ones_c);
      else                              phase_c = PHW'(2 * WIDTH - 32'(ones_c));
    end
  end

  // Next ring value and wrap detection for a step edge.
  always_comb begin
    shift_c = bus.iDir ? {q[WIDTH-2:0], ~q[WIDTH-1]} : {~q[0], q[WIDTH-1:1]};
    wrap_c  = valid_c && (bus.iDir ? (phase_c == '0) : (phase_c == PHW'(2 * WIDTH - 1)));
`ifdef JOHNSON_SELFCORRECT_EN
    next_c  = valid_c ? shift_c : '0;
`else
    next_c  = shift_c;
`endif
    due_c   = (presc == PSW'(LAST));
  end

  // State, prescaler and wrap pulse; priority reset > load > step > hold.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      q     <= '0;
      presc <= '0;
      wrap  <= 1'b0;
    end else if (bus.iLoad) begin
      q     <= bus.iLoadData;
      presc <= '0;
      wrap  <= 1'b0;
    end else if (bus.iEnable) begin
      if (due_c) begin
        q     <= next_c;
        presc <= '0;
        wrap  <= wrap_c;
      end else begin
        presc <= presc + PSW'(1);
        wrap  <= 1'b0;
      end
    end else begin
      wrap  <= 1'b0;
    end
  end

  assign bus.oSalida  = q;
  assign bus.oPhase   = phase_c;
  assign bus.oWrap    = wrap;
  assign bus.oIllegal = ~valid_c;

endmodule

// File: tb/tb_johnson_counter_param.sv
// Directed bench for johnson_counter_param: three instances
// (W4/P1, W4/P3, W5/P1) checked against hand-computed sequences.
module tb_johnson_counter_param;

  logic clk;
  logic rst_a, rst_b, rst_c;
  int   n_checks;
  int   n_fail;

  johnson_counter_param_if #(.WIDTH(4)) if_a ();
  johnson_counter_param_if #(.WIDTH(4)) if_b ();
  johnson_counter_param_if #(.WIDTH(5)) if_c ();

  johnson_counter_param #(.WIDTH(4), .PRESCALE(1)) dut_a (.iClk(clk), .iReset(rst_a), .bus(if_a.slave));
  johnson_counter_param #(.WIDTH(4), .PRESCALE(3)) dut_b (.iClk(clk), .iReset(rst_b), .bus(if_b.slave));
  johnson_counter_param #(.WIDTH(5), .PRESCALE(1)) dut_c (.iClk(clk), .iReset(rst_c), .bus(if_c.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit for sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] fwd4 [8];
    logic [4:0] fwd5 [10];
    fwd4 = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    fwd5 = '{5'b10000, 5'b11000, 5'b11100, 5'b11110, 5'b11111,
             5'b01111, 5'b00111, 5'b00011, 5'b00001, 5'b00000};
    n_checks = 0;
    n_fail   = 0;

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    if_a.iEnable = 1'b0; if_a.iDir = 1'b0; if_a.iLoad = 1'b0; if_a.iLoadData = '0;
    if_b.iEnable = 1'b0; if_b.iDir = 1'b0; if_b.iLoad = 1'b0; if_b.iLoadData = '0;
    if_c.iEnable = 1'b0; if_c.iDir = 1'b0; if_c.iLoad = 1'b0; if_c.iLoadData = '0;
    tick();
    tick();
    check("a_rst_salida",  32'(if_a.oSalida),  0);
    check("a_rst_phase",   32'(if_a.oPhase),   0);
    check("a_rst_wrap",    32'(if_a.oWrap),    0);
    check("a_rst_illegal", 32'(if_a.oIllegal), 0);

    // W4/P1 forward full cycle, then reverse across the wrap
    rst_a = 1'b0;
    if_a.iEnable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("a_fwd_salida_%0d", i), 32'(if_a.oSalida), 32'(fwd4[i]));
      check($sformatf("a_fwd_phase_%0d", i),  32'(if_a.oPhase),  (i + 1) % 8);
      check($sformatf("a_fwd_wrap_%0d", i),   32'(if_a.oWrap),   (i == 7) ? 1 : 0);
    end
    if_a.iDir = 1'b1;
    tick();
    check("a_rev_salida_0", 32'(if_a.oSalida), 4'b0001);
    check("a_rev_phase_0",  32'(if_a.oPhase),  7);
    check("a_rev_wrap_0",   32'(if_a.oWrap),   1);
    tick();
    check("a_rev_salida_1", 32'(if_a.oSalida), 4'b0011);
    check("a_rev_phase_1",  32'(if_a.oPhase),  6);
    check("a_rev_wrap_1",   32'(if_a.oWrap),   0);
    tick();
    check("a_rev_salida_2", 32'(if_a.oSalida), 4'b0111);
    check("a_rev_phase_2",  32'(if_a.oPhase),  5);

    // Illegal load and the following step
    if_a.iLoad = 1'b1; if_a.iLoadData = 4'b1010; if_a.iDir = 1'b0;
    tick();
    check("a_ill_salida",  32'(if_a.oSalida),  4'b1010);
    check("a_ill_flag",    32'(if_a.oIllegal), 1);
    check("a_ill_phase",   32'(if_a.oPhase),   0);
    if_a.iLoad = 1'b0;
    tick();
`ifdef JOHNSON_SELFCORRECT_EN
    check("a_ill_step_salida", 32'(if_a.oSalida),  4'b0000);
    check("a_ill_step_flag",   32'(if_a.oIllegal), 0);
`else
    check("a_ill_step_salida", 32'(if_a.oSalida),  4'b1101);
    check("a_ill_step_flag",   32'(if_a.oIllegal), 1);
`endif
    check("a_ill_step_wrap", 32'(if_a.oWrap), 0);

    // W4/P3: one step every 3 enabled cycles, hold while disabled
    rst_b = 1'b0;
    if_b.iEnable = 1'b1;
    tick(); check("b_p_1", 32'(if_b.oSalida), 4'b0000);
    tick(); check("b_p_2", 32'(if_b.oSalida), 4'b0000);
    tick(); check("b_p_3", 32'(if_b.oSalida), 4'b1000);
    tick(); check("b_p_4", 32'(if_b.oSalida), 4'b1000);
    tick(); check("b_p_5", 32'(if_b.oSalida), 4'b1000);
    tick(); check("b_p_6", 32'(if_b.oSalida), 4'b1100);
    tick(); check("b_p_7", 32'(if_b.oSalida), 4'b1100);
    if_b.iEnable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("b_hold_%0d", i), 32'(if_b.oSalida), 4'b1100);
    end
    if_b.iEnable = 1'b1;
    tick(); check("b_resume_1", 32'(if_b.oSalida), 4'b1100);
    tick(); check("b_resume_2", 32'(if_b.oSalida), 4'b1110);
    check("b_resume_phase", 32'(if_b.oPhase), 3);
    tick(); tick();
    check("b_pre_load", 32'(if_b.oSalida), 4'b1110);
    // Step is due on this edge; the load must win
    if_b.iLoad = 1'b1; if_b.iLoadData = 4'b1110;
    tick();
    check("b_load_salida", 32'(if_b.oSalida), 4'b1110);
    check("b_load_phase",  32'(if_b.oPhase),  3);
    if_b.iLoad = 1'b0;
    tick(); check("b_post_1", 32'(if_b.oSalida), 4'b1110);
    tick(); check("b_post_2", 32'(if_b.oSalida), 4'b1110);
    tick();
    check("b_post_3",       32'(if_b.oSalida), 4'b1111);
    check("b_post_3_phase", 32'(if_b.oPhase),  4);

    // W5/P1: full 10-state cycle, reverse wrap, then async reset mid-cycle
    rst_c = 1'b0;
    if_c.iEnable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("c_fwd_salida_%0d", i), 32'(if_c.oSalida), 32'(fwd5[i]));
      check($sformatf("c_fwd_phase_%0d", i),  32'(if_c.oPhase),  (i + 1) % 10);
      check($sformatf("c_fwd_wrap_%0d", i),   32'(if_c.oWrap),   (i == 9) ? 1 : 0);
    end
    if_c.iDir = 1'b1;
    tick();
    check("c_rev_salida", 32'(if_c.oSalida), 5'b00001);
    check("c_rev_phase",  32'(if_c.oPhase),  9);
    check("c_rev_wrap",   32'(if_c.oWrap),   1);
    #2;
    rst_c = 1'b1;
    #1;
    check("c_async_salida", 32'(if_c.oSalida), 0);
    check("c_async_wrap",   32'(if_c.oWrap),   0);
    check("c_async_phase",  32'(if_c.oPhase),  0);
    tick();
    check("c_rst_hold", 32'(if_c.oSalida), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/johnson_counter_param.md
Name: johnson_counter_param

Overview:
Parametrised Johnson (twisted-ring) counter with 2*WIDTH states, enable, up/down direction, parallel load, programmable step prescaler, phase decode, wrap pulse and illegal-state flag. It sits beside the existing 4-bit Johnson sequencers as the general-purpose phase/sequence generator for multi-phase enables and display scanning. Default configuration reproduces the 8-state sequence 0000,1000,1100,1110,1111,0111,0011,0001.

Parameters:
WIDTH, 4, ring width in bits; legal range 2 or more; state count is 2*WIDTH.
PRESCALE, 1, clock cycles per step while enabled; legal range 1 or more; 1 means a step on every enabled cycle.

Ports:
iClk  input  1  clock; all state updates on the rising edge.
iReset  input  1  asynchronous, active-high reset.
iEnable  input  1  counting enable; when low, state and prescaler hold.
iDir  input  1  0 = forward (up) sequence, 1 = reverse (down) sequence.
iLoad  input  1  synchronous parallel load strobe.
iLoadData  input  WIDTH  value loaded into the ring on iLoad.
oSalida  output  WIDTH  current ring state, MSB = bit WIDTH-1.
oPhase  output  PHW  decoded phase index 0..2*WIDTH-1, where PHW = $clog2(2*WIDTH).
oWrap  output  1  one-cycle pulse marking a sequence wrap.
oIllegal  output  1  high while oSalida is not a valid Johnson code.

Behaviour:
- Reset (async, iReset=1): oSalida=0, prescaler=0, oWrap=0; therefore oPhase=0 and oIllegal=0. Outputs hold these values until the first rising edge after iReset deasserts.
- Priority per edge: reset > load > step > hold.
- Load: when iLoad=1, oSalida<=iLoadData and prescaler<=0, regardless of iEnable or the prescaler; oWrap<=0.
- Step condition: iEnable=1, iLoad=0 and prescaler==PRESCALE-1. The prescaler then returns to 0.
- Prescaler: when iEnable=1 and no step occurs, prescaler increments. When iEnable=0, the prescaler holds its value and is not cleared.
- Forward step (iDir=0): next = {~Q[0], Q[WIDTH-1:1]}.
- Reverse step (iDir=1): next = {Q[WIDTH-2:0], ~Q[WIDTH-1]}.
- iDir is sampled only on the step edge; a direction change mid-prescale takes effect at the next step.
- Valid code: at most one index i in 0..WIDTH-2 with Q[i]!=Q[i+1]. Exactly 2*WIDTH codes satisfy this.
- oIllegal is combinational from oSalida: it is the inverse of the valid-code test.
- oPhase is combinational from oSalida:
  - Form 1^k 0^(W-k), 0<=k<=W: phase = k.
  - Form 0^(W-b) 1^b, 1<=b<=W-1: phase = 2W-b.
  - Illegal code: oPhase=0.
- Latency: oSalida and oWrap change 1 cycle after the step edge is sampled. oPhase and oIllegal follow oSalida with no extra cycle.
- oWrap: registered; set to 1 on a step edge that moves phase 2W-1 -> 0 (forward) or 0 -> 2W-1 (reverse). It is 0 after every other edge, so it is high for exactly one cycle per wrap.
- Illegal state without the optional feature: steps apply the same shift rules; the counter stays in the illegal orbit and oIllegal stays high.
- Reset asserted mid-prescale or mid-step: immediate return to the reset values; no wrap pulse is generated.

Optional Feature:
JOHNSON_SELFCORRECT_EN
- Defined: on any step edge while oIllegal=1, oSalida<=0 instead of the shift result. oWrap is not pulsed on that edge. Loads are still taken as given, so an illegal load raises oIllegal until the next step.
- Undefined: no correction; illegal codes circulate as described in Behaviour.

Test Plan:
- WIDTH=4, PRESCALE=1, iEnable=1, iDir=0 after reset: expected oSalida sequence 0000,1000,1100,1110,1111,0111,0011,0001,0000. Expected oPhase sequence 0..7,0. oWrap high only in the cycle showing 0000 after 0001.
- WIDTH=4, iDir=1 from 0000: oSalida 0001 with oPhase=7 and oWrap=1 for one cycle. Then 0011 (oPhase=6) and 0111 (oPhase=5).
- WIDTH=4, PRESCALE=3, iEnable=1: exactly one step every 3 cycles. Drop iEnable for 5 cycles mid-count: no step, and the prescaler resumes from its held value.
- iLoad=1 with iLoadData=1110 while a step is due: oSalida=1110 (oPhase=3) next cycle, no step applied. The next step then occurs 3 enabled cycles later (PRESCALE=3).
- Load 1010: oIllegal=1 and oPhase=0.
  - Without JOHNSON_SELFCORRECT_EN: the next forward step gives 1101, with oIllegal still 1.
  - With JOHNSON_SELFCORRECT_EN: the next step gives 0000 and oIllegal=0.
- WIDTH=5: full 10-state forward cycle. Assert iReset asynchronously mid-cycle: oSalida=00000 immediately, before any clock edge, with oWrap=0.
